// File: rtl/data_mem_pkg.sv
// Shared types and default sizing for the data memory controller.
//   state_e     : controller FSM state (ST_CLEAR zeroes memory, ST_READY serves requests)
//   DEF_DATA_W  : default data word width
//   DEF_ADDR_W  : default request address width
//   DEF_DEPTH   : default number of words
package data_mem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DEPTH  = 16;

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x DATA_W storage array with one write port and one synchronous read port.
// Contents are not reset; the controller's clear engine zeroes them.
//   clk    in  clock
//   we     in  write enable
//   waddr  in  write word index
//   wdata  in  write data
//   re     in  read enable; rdata updates only when re=1, otherwise holds
//   raddr  in  read word index
//   rdata  out registered read data
module data_mem_array
  import data_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: valid/ready request port, single-entry response register,
// out-of-range address flagging and a clear engine that zeroes every word after reset
// or on a clear_req pulse.
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request accepted when req_valid && req_ready
//   req_we     in   1 = write, 0 = read
//   req_addr   in   word address
//   req_wdata  in   write data
//   rsp_valid  out  response present
//   rsp_ready  in   response consumed when rsp_valid && rsp_ready
//   rsp_rdata  out  read data; 0 for writes and errors
//   rsp_err    out  address was >= DEPTH
//   clear_req  in   one-cycle pulse requesting a full clear
//   busy       out  clear engine running
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic              clear_req,
  output logic              busy
);

  localparam int               IDX_W     = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_e            state_q;
  state_e            state_d;
  logic [IDX_W-1:0]  clr_ptr_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic              rsp_rd_q;

  logic              addr_ok;
  logic              accept;
  logic [IDX_W-1:0]  req_idx;
  logic              busy_c;
  logic              ready_c;

  logic              arr_we;
  logic [IDX_W-1:0]  arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic              arr_re;
  logic [DATA_W-1:0] arr_rdata;

  // Full-width compare: upper address bits are checked, never dropped.
  assign addr_ok = ({1'b0, req_addr} < DEPTH_EXT);
  assign req_idx = req_addr[IDX_W-1:0];
  assign accept  = req_valid && ready_c;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clr_ptr_q == LAST_IDX) state_d = ST_READY;
      ST_READY: if (clear_req)             state_d = ST_CLEAR;
      default:                             state_d = ST_CLEAR;
    endcase
  end

  // FSM outputs; req_ready depends only on state, clear_req and the response slot.
  always_comb begin
    busy_c  = 1'b0;
    ready_c = 1'b0;
    case (state_q)
      ST_CLEAR: busy_c  = 1'b1;
      ST_READY: ready_c = !clear_req && (!rsp_valid_q || rsp_ready);
      default:  busy_c  = 1'b1;
    endcase
  end

  assign busy      = busy_c;
  assign req_ready = ready_c;

  // Clear pointer: walks 0..DEPTH-1 in CLEAR, reloads 0 when a clear is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_ptr_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      clr_ptr_q <= (clr_ptr_q == LAST_IDX) ? '0 : clr_ptr_q + 1'b1;
    end else if (clear_req) begin
      clr_ptr_q <= '0;
    end
  end

  // Write port shared by clear engine and requests; requests are never accepted in CLEAR.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = req_idx;
    arr_wdata = req_wdata;
    if (busy_c) begin
      arr_we    = 1'b1;
      arr_waddr = clr_ptr_q;
      arr_wdata = '0;
    end else if (accept && req_we && addr_ok) begin
      arr_we    = 1'b1;
    end
  end

  assign arr_re = accept && !req_we && addr_ok;

  data_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (arr_re),
    .raddr (req_idx),
    .rdata (arr_rdata)
  );

  // Response register: loads on accept, clears on drain, holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      rsp_err_q   <= !addr_ok;
      rsp_rd_q    <= !req_we && addr_ok;
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  // The array's read register only updates on valid reads, so it doubles as the
  // response data holding register; writes and errors present zero.
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rd_q ? arr_rdata : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       clear_req;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference contents of the 16-word memory.
  logic [7:0] ref_mem [16];

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } rsp_t;

  always #5 clk = ~clk;

  data_mem_ctrl #(
    .DATA_W (8),
    .ADDR_W (8),
    .DEPTH  (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .clear_req (clear_req),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd0;
    req_wdata = 8'd0; rsp_ready = 1'b1; clear_req = 1'b0;
    tick(); tick();
    n_cmp++;
    if (busy !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 8'h00 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state busy=%b ready=%b rv=%b rd=%h err=%b required 1 0 0 00 0",
               busy, req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (busy !== 1'b1 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL init_busy cyc=%0d busy=%b ready=%b required 1 0", i, busy, req_ready);
      end
      tick();
    end
    n_cmp++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL init_done busy=%b ready=%b required 0 1", busy, req_ready);
    end
    for (int k = 0; k < 16; k++) begin
      req_addr = 8'(k);
      tick();
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h00 || rsp_err !== 1'b0) begin
        n_fail++;
        $display("FAIL init_zero addr=%0d rv=%b rd=%h err=%b required 1 00 0", k, rsp_valid, rsp_rdata, rsp_err);
      end
    end
    req_valid = 1'b0;
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL init_drain rv=%b required 0", rsp_valid);
    end
    for (int k = 0; k < 16; k++) ref_mem[k] = 8'h00;
  endtask

  task automatic test_write_read();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd3; req_wdata = 8'hA5;
    tick();
    ref_mem[3] = 8'hA5;
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h00 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_rsp rv=%b rd=%h err=%b required 1 00 0", rsp_valid, rsp_rdata, rsp_err);
    end
    req_we = 1'b0; req_wdata = 8'h00;
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_after_wr rv=%b rd=%h err=%b required 1 a5 0", rsp_valid, rsp_rdata, rsp_err);
    end
    req_valid = 1'b0;
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_rd_drain rv=%b required 0", rsp_valid);
    end
  endtask

  task automatic test_range();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd3; req_wdata = 8'h5A;
    tick();
    ref_mem[3] = 8'h5A;
    req_we = 1'b1; req_addr = 8'h13; req_wdata = 8'hEE;
    tick();
    n_cmp++;
    if (rsp_err !== 1'b1 || rsp_rdata !== 8'h00 || rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_write err=%b rd=%h rv=%b required 1 00 1", rsp_err, rsp_rdata, rsp_valid);
    end
    req_we = 1'b0; req_addr = 8'h13;
    tick();
    n_cmp++;
    if (rsp_err !== 1'b1 || rsp_rdata !== 8'h00 || rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_read err=%b rd=%h rv=%b required 1 00 1", rsp_err, rsp_rdata, rsp_valid);
    end
    req_addr = 8'd3;
    tick();
    n_cmp++;
    if (rsp_err !== 1'b0 || rsp_rdata !== 8'h5A) begin
      n_fail++;
      $display("FAIL no_alias err=%b rd=%h required 0 5a", rsp_err, rsp_rdata);
    end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd3;
    tick();
    req_addr = 8'd2;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 8'h5A || rsp_err !== 1'b0) begin
        n_fail++;
        $display("FAIL stall cyc=%0d ready=%b rv=%b rd=%h err=%b required 0 1 5a 0",
                 i, req_ready, rsp_valid, rsp_rdata, rsp_err);
      end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_ready ready=%b required 1", req_ready);
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[2] || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_rsp rv=%b rd=%h err=%b required 1 %h 0", rsp_valid, rsp_rdata, rsp_err, ref_mem[2]);
    end
    req_valid = 1'b0;
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drop rv=%b required 0", rsp_valid);
    end
  endtask

  task automatic test_random();
    rsp_t q[$];
    rsp_t e;
    logic exp_ready;
    for (int c = 0; c < 400; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 15));
      req_wdata = 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = (q.size() == 0) || rsp_ready;
      n_cmp++;
      if (req_ready !== exp_ready || rsp_valid !== (q.size() != 0)) begin
        n_fail++;
        $display("FAIL rnd_hs cyc=%0d ready=%b rv=%b required %b %b", c, req_ready, rsp_valid, exp_ready, q.size() != 0);
      end
      if (q.size() != 0) begin
        n_cmp++;
        if (rsp_rdata !== q[0].rdata || rsp_err !== q[0].err) begin
          n_fail++;
          $display("FAIL rnd_rsp cyc=%0d rd=%h err=%b required %h %b", c, rsp_rdata, rsp_err, q[0].rdata, q[0].err);
        end
      end
      if (q.size() != 0 && rsp_ready) void'(q.pop_front());
      if (req_valid && exp_ready) begin
        if (req_addr >= 8'd16) begin
          e.rdata = 8'h00; e.err = 1'b1;
        end else if (req_we) begin
          ref_mem[req_addr[3:0]] = req_wdata;
          e.rdata = 8'h00; e.err = 1'b0;
        end else begin
          e.rdata = ref_mem[req_addr[3:0]]; e.err = 1'b0;
        end
        q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    tick();
  endtask

  task automatic test_clear();
    rsp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_wdata = 8'hFF;
    for (int k = 0; k < 16; k++) begin
      req_addr = 8'(k);
      tick();
    end
    req_valid = 1'b0;
    tick();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd0; clear_req = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_ready ready=%b required 0", req_ready);
    end
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      clear_req = (i == 4);
      #1;
      n_cmp++;
      if (busy !== 1'b1 || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL clr_busy cyc=%0d busy=%b ready=%b required 1 0", i, busy, req_ready);
      end
      tick();
    end
    clear_req = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_done busy=%b ready=%b required 0 1", busy, req_ready);
    end
    for (int k = 0; k < 16; k++) ref_mem[k] = 8'h00;
    for (int k = 0; k < 16; k++) begin
      req_addr = 8'(k);
      tick();
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h00 || rsp_err !== 1'b0) begin
        n_fail++;
        $display("FAIL clr_zero addr=%0d rv=%b rd=%h err=%b required 1 00 0", k, rsp_valid, rsp_rdata, rsp_err);
      end
    end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_midclear();
    rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd5;
    tick();
    req_valid = 1'b0; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rsp_survives rv=%b busy=%b required 1 1", rsp_valid, busy);
    end
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst rv=%b busy=%b ready=%b required 0 1 0", rsp_valid, busy, req_ready);
    end
    tick();
    rst_n = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_busy cyc=%0d busy=%b rv=%b required 1 0", i, busy, rsp_valid);
      end
      tick();
    end
    n_cmp++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_done busy=%b ready=%b required 0 1", busy, req_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish by 200000 required finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_range();
    test_backpressure();
    test_random();
    test_clear();
    test_reset_midclear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
